// File: rtl/pipe_pkg.sv
// Shared definitions for the integer pipeline hazard logic: forwarding source
// encoding and the shadow scoreboard entry.
package pipe_pkg;
  localparam int SIZE  = 32;
  localparam int REG_W = $clog2(SIZE);

  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMMEM2 = 2'd2;
  localparam logic [1:0] FWD_MEM2WB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scheduler_perf_counters.sv
// Free-running CPI counters: cycles, retires, stall cycles and flush cycles.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_en,
  input  logic             stall_en,
  input  logic             flush_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  // All counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire_en) retire_cnt <= retire_cnt + 1'b1;
      if (stall_en)  stall_cnt  <= stall_cnt + 1'b1;
      if (flush_en)  flush_cnt  <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the IF/ID/EX/MEM/MEM2/WB pipeline: load-use stall,
// EX operand forwarding select, taken-branch flush and performance counters.
module hazard_scheduler #(
  parameter int SIZE  = pipe_pkg::SIZE,
  parameter int CNT_W = 32,
  localparam int REG_W = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipe_pkg::*;

  // Index 0 = EX, 1 = MEM, 2 = MEM2, 3 = WB.
  sb_entry_t  sb [4];
  logic       issue;
  logic       load_hit;
  logic [1:0] fwd_rs_nxt;
  logic [1:0] fwd_rt_nxt;

  function automatic logic hit(input logic used, input logic [REG_W-1:0] r,
                               input sb_entry_t e);
    return used && (r != '0) && e.valid && (e.dest == r);
  endfunction

  // Youngest producer wins; a WB-only match reads the write-through regfile.
  function automatic logic [1:0] pick(input logic used, input logic [REG_W-1:0] r,
                                      input sb_entry_t e_ex, input sb_entry_t e_mem,
                                      input sb_entry_t e_mem2);
    if (hit(used, r, e_ex))        return FWD_EXMEM;
    else if (hit(used, r, e_mem))  return FWD_MEMMEM2;
    else if (hit(used, r, e_mem2)) return FWD_MEM2WB;
    else                           return FWD_RF;
  endfunction

  // stall holds PC and IF/ID and bubbles EX; flush kills IF and ID. Flush wins.
  always_comb begin
    flush    = ex_branch_taken & sb[0].valid;
    load_hit = ((hit(id_use_rs, id_rs, sb[0]) | hit(id_use_rt, id_rt, sb[0])) & sb[0].is_load)
             | ((hit(id_use_rs, id_rs, sb[1]) | hit(id_use_rt, id_rt, sb[1])) & sb[1].is_load);
    stall    = id_valid & ~flush & load_hit;
    issue    = id_valid & ~stall & ~flush;
    fwd_rs_nxt = FWD_RF;
    fwd_rt_nxt = FWD_RF;
    if (issue) begin
      fwd_rs_nxt = pick(id_use_rs, id_rs, sb[0], sb[1], sb[2]);
      fwd_rt_nxt = pick(id_use_rt, id_rt, sb[0], sb[1], sb[2]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) sb[i] <= '0;
      fwd_rs <= FWD_RF;
      fwd_rt <= FWD_RF;
    end else begin
      sb[0] <= issue ? sb_entry_t'{valid: id_writes, dest: id_dest, is_load: id_is_load}
                     : sb_entry_t'('0);
      sb[1] <= sb[0];
      sb[2] <= sb[1];
      sb[3] <= sb[2];
      fwd_rs <= fwd_rs_nxt;
      fwd_rt <= fwd_rt_nxt;
    end
  end

  perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .reset      (reset),
    .retire_en  (sb[3].valid),
    .stall_en   (stall),
    .flush_en   (flush),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );
endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed scoreboard bench for hazard_scheduler: stall, flush, forwarding
// selects and performance counters.
module tb_hazard_scheduler;
  localparam int CNT_W = 32;
  localparam int EW    = 6;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_writes;
  logic [4:0]       id_dest;
  logic             id_is_load;
  logic             ex_branch_taken;
  logic             stall;
  logic             flush;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            failures;
  logic [CNT_W-1:0] base_r;
  logic [CNT_W-1:0] base_c;

  hazard_scheduler #(.SIZE(32), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_writes       (id_writes),
    .id_dest         (id_dest),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .fwd_rs          (fwd_rs),
    .fwd_rt          (fwd_rt),
    .cycle_cnt       (cycle_cnt),
    .retire_cnt      (retire_cnt),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive one ID-stage cycle and queue the expected {stall, flush, fwd_rs, fwd_rt}.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] dst, input logic ld, input logic br,
                       input logic es, input logic ef,
                       input logic [1:0] efrs, input logic [1:0] efrt, input string nm);
    @(negedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_writes = wr; id_dest = dst; id_is_load = ld; ex_branch_taken = br;
    exp_q.push_back({es, ef, efrs, efrt});
    name_q.push_back(nm);
  endtask

  task automatic nop(input logic [1:0] efrs, input logic [1:0] efrt, input string nm);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efrs, efrt, nm);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) nop(0, 0, "drain");
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    string nm;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_stall"},  32'(stall),  32'(e[5]));
        check({nm, "_flush"},  32'(flush),  32'(e[4]));
        check({nm, "_fwd_rs"}, 32'(fwd_rs), 32'(e[3:2]));
        check({nm, "_fwd_rt"}, 32'(fwd_rt), 32'(e[1:0]));
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_writes = 0; id_dest = 0; id_is_load = 0; ex_branch_taken = 0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_fwd", 32'({fwd_rs, fwd_rt}), 0);
    check("rst_cycle", cycle_cnt, 0);
    reset = 1'b0;

    // Dependent ALU ops: add r3,r1,r2 ; add r4,r3,r3
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, "t1_prod");
    drive(1, 3, 3, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, "t1_cons");
    nop(1, 1, "t1_fwd");
    nop(0, 0, "t1_noissue");
    drain(3);

    // Forward code by producer distance, youngest-wins, unused operand.
    drive(1, 1, 2, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, "cd_prod");
    nop(0, 0, "cd_gap");
    drive(1, 9, 0, 1, 1, 1, 10, 0, 0, 0, 0, 0, 0, "cd_mem");
    drive(1, 1, 9, 1, 1, 1, 11, 0, 0, 0, 0, 2, 0, "cd_mem2");
    drive(1, 9, 9, 1, 1, 1, 12, 0, 0, 0, 0, 0, 3, "cd_wb");
    nop(0, 0, "cd_wb_only");
    drive(1, 1, 2, 1, 1, 1, 13, 0, 0, 0, 0, 0, 0, "yw_old");
    drive(1, 1, 2, 1, 1, 1, 13, 0, 0, 0, 0, 0, 0, "yw_new");
    drive(1, 13, 13, 1, 1, 1, 14, 0, 0, 0, 0, 0, 0, "yw_cons");
    nop(1, 1, "yw_fwd");
    drive(1, 1, 2, 1, 1, 1, 15, 0, 0, 0, 0, 0, 0, "uf_prod");
    drive(1, 15, 15, 0, 1, 1, 16, 0, 0, 0, 0, 0, 0, "uf_cons");
    nop(0, 1, "uf_fwd");
    drain(4);

    // Back-to-back load-use: lw r5 ; add r6,r5,r0
    drive(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, "t2_lw");
    drive(1, 5, 0, 1, 1, 1, 6, 0, 0, 1, 0, 0, 0, "t2_stall1");
    drive(1, 5, 0, 1, 1, 1, 6, 0, 0, 1, 0, 0, 0, "t2_stall2");
    drive(1, 5, 0, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, "t2_issue");
    nop(3, 0, "t2_fwd");
    drain(4);
    check("t2_stall_cnt", stall_cnt, 2);

    // Load, one gap, consumer: exactly one stall.
    drive(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, "t3_lw");
    nop(0, 0, "t3_gap");
    drive(1, 5, 1, 1, 1, 1, 6, 0, 0, 1, 0, 0, 0, "t3_stall");
    drive(1, 5, 1, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, "t3_issue");
    nop(3, 0, "t3_fwd");
    drain(4);
    check("t3_stall_cnt", stall_cnt, 3);

    // Register 0 never hazards or forwards, not even after a load to r0.
    drive(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_w0");
    drive(1, 0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, "t4_r0");
    nop(0, 0, "t4_fwd");
    drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, "t4_lw_r0");
    drive(1, 0, 0, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, "t4_use_r0");
    nop(0, 0, "t4_fwd2");
    drain(4);

    // Taken branch in EX while ID has a load-use hazard on a load in MEM.
    drive(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0, "t5_lw");
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, "t5_br");
    drive(1, 5, 0, 1, 1, 1, 6, 0, 1, 0, 1, 0, 0, "t5_flush");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "t5_bubble");
    drain(5);
    check("t5_flush_cnt", flush_cnt, 1);
    check("t5_stall_cnt", stall_cnt, 3);

    // Retire counting: two writers and one non-writer over 8 cycles.
    base_r = retire_cnt;
    base_c = cycle_cnt;
    drive(1, 1, 2, 1, 1, 1, 20, 0, 0, 0, 0, 0, 0, "rt_w1");
    drive(1, 1, 2, 1, 1, 1, 21, 0, 0, 0, 0, 0, 0, "rt_w2");
    drive(1, 1, 2, 1, 1, 0, 22, 0, 0, 0, 0, 0, 0, "rt_nw");
    drain(5);
    check("rt_retire_delta", retire_cnt - base_r, 2);
    check("rt_cycle_delta", cycle_cnt - base_c, 8);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    // Mid-stream reset with a pending load-use stall.
    @(negedge clk);
    #1;
    id_valid = 1; id_rs = 1; id_use_rs = 1; id_use_rt = 0; id_writes = 1;
    id_dest = 5; id_is_load = 1; ex_branch_taken = 0;
    @(negedge clk);
    #1;
    id_rs = 5; id_dest = 6; id_is_load = 0;
    #1;
    check("t6_pre_stall", 32'(stall), 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_stall", 32'(stall), 0);
    check("t6_flush", 32'(flush), 0);
    check("t6_fwd", 32'({fwd_rs, fwd_rt}), 0);
    check("t6_cycle", cycle_cnt, 0);
    check("t6_retire", retire_cnt, 0);
    check("t6_stall_cnt", stall_cnt, 0);
    check("t6_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    #1;
    id_valid = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t6_cycle_after", cycle_cnt, 1);
    check("t6_stall_after", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
